// File: rtl/fetch_responder_pkg.sv
// Shared definitions for the instruction-fetch responder: FSM encoding,
// fetch-length limit and the default code-memory address width.
package fetch_responder_pkg;

  localparam int DEFAULT_ADDR_BITS = 8;
  localparam int MAX_LEN           = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_t;

  // Lengths outside 1..MAX_LEN fall back to a full word.
  function automatic logic [2:0] eff_len(input logic [2:0] len);
    return (len == 3'd0 || len > 3'(MAX_LEN)) ? 3'(MAX_LEN) : len;
  endfunction

endpackage

// File: rtl/fetch_responder_if.sv
// Fetch-side request/response bundle between a fetch unit (master) and
// the responder (slave).
interface fetch_responder_if;

  logic        req;
  logic [31:0] addr;
  logic [2:0]  len;
  logic        busy;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, addr, len, input busy, ack, rdata);
  modport slave  (input req, addr, len, output busy, ack, rdata);

endinterface

// File: rtl/code_byte_ram.sv
// Byte-wide code memory: one synchronous write port, one asynchronous
// read port. A same-cycle read of the written address sees the old byte.
module code_byte_ram
  import fetch_responder_pkg::*;
#(
  parameter int ADDR_BITS = DEFAULT_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [7:0]           wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [7:0]           rdata
);

  logic [7:0] mem [2**ADDR_BITS];

  // NOTE: storage arrays get no reset: contents must survive a block reset,
  // and a reset port would stop the array mapping onto plain RAM.
  // NOTE: non-blocking write so the async read sees the pre-edge byte for
  // the whole cycle, which is what gives read-old behaviour.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_responder.sv
// Fetch responder: accepts a 1..4 byte fetch, gathers bytes from the code
// memory one per cycle (first byte in [31:24]) and pulses ack with the word.
module fetch_responder
  import fetch_responder_pkg::*;
#(
  parameter int ADDR_BITS = DEFAULT_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_responder_if.slave     bus,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [7:0]           wdata
);

  state_t               state, state_next;
  logic [ADDR_BITS-1:0] base;
  logic [ADDR_BITS-1:0] raddr;
  logic [2:0]           cnt;
  logic [2:0]           len_q;
  logic [1:0]           lane;
  logic [31:0]          word;
  logic [7:0]           ram_byte;
  logic                 last;
  logic                 busy;
  logic                 ack;

  code_byte_ram #(.ADDR_BITS(ADDR_BITS)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (ram_byte)
  );

  // Address wraps naturally in the ADDR_BITS-wide sum.
  assign raddr = base + ADDR_BITS'(cnt);
  assign lane  = 2'd3 - cnt[1:0];
  assign last  = (cnt == len_q - 3'd1);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    // NOTE: every output gets a default before the case, so no path can
    // leave a signal unassigned and infer a latch.
    state_next = state;
    busy       = 1'b1;
    ack        = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (bus.req) state_next = READ;
      end
      READ:    if (last) state_next = RESP;
      RESP: begin
        ack        = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      base  <= '0;
      cnt   <= '0;
      len_q <= '0;
      word  <= '0;
    end else begin
      case (state)
        IDLE: if (bus.req) begin
          base  <= bus.addr[ADDR_BITS-1:0];
          len_q <= eff_len(bus.len);
          cnt   <= '0;
          word  <= '0;
        end
        READ: begin
          word[{lane, 3'b000} +: 8] <= ram_byte;
          cnt                       <= cnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = busy;
  assign bus.ack   = ack;
  assign bus.rdata = word;

  // Only the low address bits index the code memory.
  logic unused_addr;
  assign unused_addr = ^bus.addr[31:ADDR_BITS];

endmodule

// File: tb/tb_fetch_responder.sv
// Scoreboard bench for fetch_responder: the driver predicts each accepted
// fetch from a byte-array model; a negedge monitor checks busy/ack/rdata.
module tb_fetch_responder;

  localparam int AB = 8;

  typedef struct {
    int          ack_edge;
    logic [7:0]  base;
    int          len;
    logic [31:0] word;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       we;
  logic [7:0] waddr;
  logic [7:0] wdata;

  fetch_responder_if bus();

  fetch_responder #(.ADDR_BITS(AB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata)
  );

  always #5 clk = ~clk;

  exp_t        sb[$];
  logic [7:0]  ref_mem [256];
  int          edges     = 0;
  int          free_edge = 0;
  logic [31:0] hold      = '0;
  bit          mon_en    = 1'b0;
  int          n_vec     = 0;
  int          n_err     = 0;

  always @(posedge clk) edges <= edges + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at edge %0d: got %h, want %h", name, edges, act, exp);
    end
  endtask

  // Monitor: runs on the falling edge, well away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      check("busy", 32'(bus.busy), 32'(sb.size() > 0));
      if (sb.size() > 0 && sb[0].ack_edge == edges) begin
        check("ack", 32'(bus.ack), 32'd1);
        check("rdata", bus.rdata, sb[0].word);
        hold = sb[0].word;
        void'(sb.pop_front());
      end else begin
        check("no_ack", 32'(bus.ack), 32'd0);
        if (sb.size() == 0) check("rdata_hold", bus.rdata, hold);
      end
    end
  end

  // Reference: a fetch returns len bytes (len 0 or >4 means 4) read from
  // consecutive wrapping addresses, first byte in the top lane, rest zero.
  task automatic accept(input logic [31:0] a, input logic [2:0] l);
    exp_t x;
    int   n;
    n = (l >= 3'd1 && l <= 3'd4) ? int'(l) : 4;
    x.word = '0;
    for (int k = 0; k < n; k++)
      x.word[31 - 8*k -: 8] = ref_mem[a[7:0] + 8'(k)];
    x.base     = a[7:0];
    x.len      = n;
    x.ack_edge = edges + n;
    sb.push_back(x);
    free_edge = edges + n + 2;
  endtask

  // Drive one cycle, then update the model for the edge just taken.
  task automatic cyc(input bit r, input bit rq, input logic [31:0] a, input logic [2:0] l,
                     input bit w, input logic [7:0] wa, input logic [7:0] wd);
    reset    = r;
    bus.req  = rq;
    bus.addr = a;
    bus.len  = l;
    we       = w;
    waddr    = wa;
    wdata    = wd;
    @(posedge clk);
    #1;
    if (w) ref_mem[wa] = wd;
    if (!r) begin
      sb.delete();
      free_edge = edges + 1;
      hold      = '0;
    end else if (rq && edges >= free_edge) begin
      accept(a, l);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b1, 1'b0, 32'h0, 3'd0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic wr(input logic [7:0] wa, input logic [7:0] wd);
    cyc(1'b1, 1'b0, 32'h0, 3'd0, 1'b1, wa, wd);
  endtask

  task automatic fetch(input logic [31:0] a, input logic [2:0] l);
    cyc(1'b1, 1'b1, a, l, 1'b0, 8'h00, 8'h00);
  endtask

  function automatic bit in_window(input logic [7:0] wa);
    logic [7:0] d;
    if (sb.size() == 0) return 1'b0;
    d = wa - sb[0].base;
    return int'(d) < sb[0].len;
  endfunction

  initial begin
    bit         r, rq, w;
    logic [31:0] a;
    logic [2:0]  l;
    logic [7:0]  wa, wd;

    bus.req = 1'b0; bus.addr = '0; bus.len = '0;
    cyc(1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 8'h00, 8'h00);
    mon_en = 1'b1;

    // Fill memory; the first writes happen with reset held low.
    for (int i = 0; i < 256; i++)
      cyc(i >= 8 ? 1'b1 : 1'b0, 1'b1, 32'h0, 3'd4, 1'b1, 8'(i), 8'($urandom));
    fetch(32'h4, 3'd4);            idle(6);

    // Basic fetch.
    wr(8'h00, 8'hB8); wr(8'h01, 8'h02); wr(8'h02, 8'h00); wr(8'h03, 8'h00);
    fetch(32'h0, 3'd4);            idle(6);
    // Short fetch.
    wr(8'h10, 8'h89); wr(8'h11, 8'hE5);
    fetch(32'h10, 3'd2);           idle(4);
    // Wrap with length clamp.
    wr(8'hFE, 8'hAA); wr(8'hFF, 8'hBB); wr(8'h00, 8'hCC); wr(8'h01, 8'hDD);
    fetch(32'h1FE, 3'd0);          idle(6);
    // Request during READ is dropped.
    fetch(32'h40, 3'd4);
    fetch(32'h10, 3'd2);           idle(6);
    // Reset two cycles after accept aborts; memory untouched.
    fetch(32'h0, 3'd4);            idle(1);
    cyc(1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 8'h00, 8'h00);
    idle(6);
    fetch(32'h0, 3'd4);            idle(6);
    // Write to the byte being loaded that cycle.
    wr(8'h21, 8'h11);
    fetch(32'h20, 3'd4);           idle(1);
    wr(8'h21, 8'h55);              idle(5);
    fetch(32'h20, 3'd4);           idle(6);
    // req held high: accepts are spaced by an IDLE cycle.
    repeat (14) fetch(32'h30, 3'd3);
    idle(6);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 39) != 0);
      rq = $urandom_range(0, 1) != 0;
      a  = $urandom;
      l  = 3'($urandom_range(0, 7));
      w  = ($urandom_range(0, 3) == 0);
      wa = 8'($urandom);
      wd = 8'($urandom);
      if (w && in_window(wa)) w = 1'b0;
      cyc(r, rq, a, l, w, wa, wd);
    end

    idle(8);
    check("drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
